// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults and configuration helpers for the pipelined ripple-carry adder.
package adder_pkg;
    localparam int ADDER_WIDTH_DEFAULT = 16;
    localparam int ADDER_CHUNK_DEFAULT = 4;

    function automatic int adder_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic bit adder_cfg_ok(input int width, input int chunk);
        return (chunk > 0) && (width >= chunk) && (width % chunk == 0);
    endfunction
endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational CHUNK-bit ripple-carry slice.
module rca_chunk
    import adder_pkg::*;
#(
    parameter int CHUNK = ADDER_CHUNK_DEFAULT
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o
);
    logic [CHUNK:0] c;

    always_comb begin
        c[0] = cin_i;
        for (int i = 0; i < CHUNK; i++)
            c[i+1] = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end

    assign s_o    = a_i ^ b_i ^ c[CHUNK-1:0];
    assign cout_o = c[CHUNK];
endmodule

// File: rtl/pipelined_rca_adder.sv
// pipelined_rca_adder: adder/subtractor with one CHUNK-bit ripple slice per register stage,
// carry registered between stages, and a single global enable driven by output backpressure.
module pipelined_rca_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT,
    parameter int CHUNK = ADDER_CHUNK_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             ovf_o
);
    localparam int STAGES = adder_stages(WIDTH, CHUNK);

    if (!adder_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("pipelined_rca_adder: WIDTH must be a positive multiple of CHUNK");
    end

    // layer 0 holds the conditioned operands; layer k+1 holds stage k's results
    logic [WIDTH-1:0]             a_d [STAGES];
    logic [WIDTH-1:0]             a_q [STAGES];
    logic [WIDTH-1:0]             b_d [STAGES];
    logic [WIDTH-1:0]             b_q [STAGES];
    logic [WIDTH-1:0]             s_d [STAGES+1];
    logic [WIDTH-1:0]             s_q [STAGES+1];
    logic [STAGES:0]              c_d, c_q, v_d, v_q;
    logic [STAGES-1:0][CHUNK-1:0] sum_w;
    logic [STAGES-1:0]            cout_w;
    logic                         ovf_d, ovf_q;
    logic                         en;

    assign en      = ready_i | ~v_q[STAGES];
    assign ready_o = en;

    genvar g;
    for (g = 0; g < STAGES; g++) begin : g_stage
        rca_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a_i    (a_q[g][g*CHUNK +: CHUNK]),
            .b_i    (b_q[g][g*CHUNK +: CHUNK]),
            .cin_i  (c_q[g]),
            .s_o    (sum_w[g]),
            .cout_o (cout_w[g])
        );
    end

    always_comb begin
        a_d[0] = a_i;
        b_d[0] = sub_i ? ~b_i : b_i;
        c_d[0] = cin_i ^ sub_i;
        v_d[0] = valid_i;
        s_d[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            s_d[k+1] = s_q[k];
            s_d[k+1][k*CHUNK +: CHUNK] = sum_w[k];
        end
        c_d[STAGES:1] = cout_w;
        v_d[STAGES:1] = v_q[STAGES-1:0];
        ovf_d = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                (sum_w[STAGES-1][CHUNK-1] != a_q[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q   <= '{default: '0};
            b_q   <= '{default: '0};
            s_q   <= '{default: '0};
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
        end else if (en) begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
        end
    end

    assign s_o     = s_q[STAGES];
    assign cout_o  = c_q[STAGES];
    assign valid_o = v_q[STAGES];
    assign ovf_o   = ovf_q;
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// tb_pipelined_rca_adder: directed checks of the pipelined adder, streaming with backpressure,
// asynchronous reset mid-flight and alternate (WIDTH, CHUNK) configurations.
module tb_pipelined_rca_adder;
    logic        clk = 1'b0;
    logic        rst_i, valid_i, ready_i, cin_i, sub_i;
    logic [15:0] a_i, b_i;
    logic        ready_o, valid_o, cout_o, ovf_o;
    logic [15:0] s_o;

    logic [31:0] xa, xb;
    logic        xcin, xsub, xvalid, xrdy;
    logic        r8, v8, c8, o8, r34, v34, c34, o34, r38, v38, c38, o38;
    logic [7:0]  s8;
    logic [31:0] s34, s38;

    int total = 0;
    int bad   = 0;

    logic [15:0] qa [1024];
    logic [15:0] qb [1024];
    logic        qc [1024];
    logic        qs [1024];
    logic [15:0] es [1024];
    logic        ec [1024];
    logic        eo [1024];

    logic [15:0] ha  [8] = '{16'h0001, 16'h0003, 16'h8000, 16'h0000, 16'h00FF, 16'h1000, 16'h4000, 16'h7FFF};
    logic [15:0] hb  [8] = '{16'h0002, 16'h0001, 16'h8000, 16'h0001, 16'h0001, 16'h0FFF, 16'h4000, 16'hFFFF};
    logic [15:0] hes [8] = '{16'h0003, 16'h0002, 16'h0000, 16'hFFFF, 16'h0101, 16'h0001, 16'h8000, 16'h8000};
    logic [7:0]  hc  = 8'b0001_0000;
    logic [7:0]  hs  = 8'b1010_1010;
    logic [7:0]  hec = 8'b0010_0110;
    logic [7:0]  heo = 8'b1100_0100;

    pipelined_rca_adder dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .a_i(a_i), .b_i(b_i), .cin_i(cin_i), .sub_i(sub_i),
        .valid_o(valid_o), .ready_i(ready_i), .s_o(s_o), .cout_o(cout_o), .ovf_o(ovf_o)
    );

    pipelined_rca_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(xvalid), .ready_o(r8),
        .a_i(xa[7:0]), .b_i(xb[7:0]), .cin_i(xcin), .sub_i(xsub),
        .valid_o(v8), .ready_i(xrdy), .s_o(s8), .cout_o(c8), .ovf_o(o8)
    );

    pipelined_rca_adder #(.WIDTH(32), .CHUNK(4)) dut34 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(xvalid), .ready_o(r34),
        .a_i(xa), .b_i(xb), .cin_i(xcin), .sub_i(xsub),
        .valid_o(v34), .ready_i(xrdy), .s_o(s34), .cout_o(c34), .ovf_o(o34)
    );

    pipelined_rca_adder #(.WIDTH(32), .CHUNK(8)) dut38 (
        .clk_i(clk), .rst_i(rst_i), .valid_i(xvalid), .ready_o(r38),
        .a_i(xa), .b_i(xb), .cin_i(xcin), .sub_i(xsub),
        .valid_o(v38), .ready_i(xrdy), .s_o(s38), .cout_o(c38), .ovf_o(o38)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] be;
        logic [16:0] t;
        be = sub ? ~b : b;
        t  = {1'b0, a} + {1'b0, be} + {16'b0, cin ^ sub};
        return {(a[15] == be[15]) && (t[15] != a[15]), t[16], t[15:0]};
    endfunction

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub,
                          input logic [15:0] xs, input logic xc, input logic xo);
        int lat;
        ready_i = 1'b1;
        a_i = a; b_i = b; cin_i = cin; sub_i = sub; valid_i = 1'b1;
        step;
        valid_i = 1'b0;
        lat = 0;
        while (!valid_o && lat < 10) begin
            step;
            lat++;
        end
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_s"}, s_o, xs);
        chk({tag, "_cout"}, cout_o, xc);
        chk({tag, "_ovf"}, ovf_o, xo);
        step;
    endtask

    // mode 0: ready always high, 1: five-cycle stall once the first result is out, 2: random ready
    task automatic stream(input int n, input int mode, output int span);
        int          snd, rcv, cyc, first;
        logic        hold, acc;
        logic [15:0] held;
        snd = 0; rcv = 0; cyc = 0; first = -1; span = -1; hold = 1'b0; held = '0;
        while (rcv < n && cyc < 20000) begin
            ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? !(cyc >= 5 && cyc < 10) : 1'($urandom_range(0, 1));
            valid_i = (snd < n);
            if (snd < n) begin
                a_i = qa[snd]; b_i = qb[snd]; cin_i = qc[snd]; sub_i = qs[snd];
            end
            #1;
            if (hold) begin
                chk("stall_valid", valid_o, 1);
                chk("stall_s", s_o, held);
            end
            if (valid_o && !ready_i) chk("stall_ready", ready_o, 0);
            if (valid_o && ready_i) begin
                chk($sformatf("m%0d_s%0d", mode, rcv), s_o, es[rcv]);
                chk($sformatf("m%0d_c%0d", mode, rcv), cout_o, ec[rcv]);
                chk($sformatf("m%0d_o%0d", mode, rcv), ovf_o, eo[rcv]);
                if (first < 0) first = cyc;
                span = cyc - first;
                rcv++;
            end
            hold = valid_o && !ready_i;
            held = s_o;
            acc  = valid_i && ready_o;
            step;
            if (acc) snd++;
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk("drained", rcv, n);
        for (int i = 0; i < 6; i++) step;
        chk("no_dup", valid_o, 0);
    endtask

    task automatic aux_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [7:0] x8, input logic xc8, input logic xo8,
                          input logic [31:0] x32, input logic xc32, input logic xo32);
        int          l8, l34, l38;
        logic [7:0]  g8;
        logic [31:0] g34, g38;
        logic        gc8, go8, gc34, go34, gc38, go38;
        l8 = -1; l34 = -1; l38 = -1;
        g8 = '0; g34 = '0; g38 = '0;
        gc8 = 0; go8 = 0; gc34 = 0; go34 = 0; gc38 = 0; go38 = 0;
        xa = a; xb = b; xsub = sub; xcin = 1'b0; xvalid = 1'b1;
        step;
        xvalid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step;
            if (v8 && l8 < 0) begin l8 = i; g8 = s8; gc8 = c8; go8 = o8; end
            if (v34 && l34 < 0) begin l34 = i; g34 = s34; gc34 = c34; go34 = o34; end
            if (v38 && l38 < 0) begin l38 = i; g38 = s38; gc38 = c38; go38 = o38; end
        end
        chk({tag, "_8_lat"}, l8, 1);
        chk({tag, "_8_s"}, g8, x8);
        chk({tag, "_8_c"}, gc8, xc8);
        chk({tag, "_8_o"}, go8, xo8);
        chk({tag, "_34_lat"}, l34, 8);
        chk({tag, "_34_s"}, g34, x32);
        chk({tag, "_34_c"}, gc34, xc32);
        chk({tag, "_34_o"}, go34, xo32);
        chk({tag, "_38_lat"}, l38, 4);
        chk({tag, "_38_s"}, g38, x32);
        chk({tag, "_38_c"}, gc38, xc32);
        chk({tag, "_38_o"}, go38, xo32);
    endtask

    initial begin
        int          span, nv, fl;
        logic [15:0] fs;
        logic [17:0] m;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
        xa = '0; xb = '0; xcin = 1'b0; xsub = 1'b0; xvalid = 1'b0; xrdy = 1'b1;
        step;
        step;
        chk("rst_valid", valid_o, 0);
        chk("rst_s", s_o, 0);
        chk("rst_cout", cout_o, 0);
        chk("rst_ovf", ovf_o, 0);
        rst_i = 1'b0;
        ready_i = 1'b0;
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_ready_aux", {r8, r34, r38}, 3'b111);
        step;

        run_op("add1", 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 0, 0);
        run_op("add2", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        run_op("add3", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        run_op("sub1", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        run_op("sub2", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
        run_op("sub3", 16'h0010, 16'h0001, 1, 1, 16'h000E, 1, 0);

        for (int i = 0; i < 8; i++) begin
            qa[i] = ha[i]; qb[i] = hb[i]; qc[i] = hc[i]; qs[i] = hs[i];
            es[i] = hes[i]; ec[i] = hec[i]; eo[i] = heo[i];
        end
        stream(8, 0, span);
        chk("b2b_span", span, 7);
        stream(8, 1, span);

        for (int i = 0; i < 1000; i++) begin
            qa[i] = 16'($urandom); qb[i] = 16'($urandom);
            qc[i] = 1'($urandom_range(0, 1)); qs[i] = 1'($urandom_range(0, 1));
            m = model(qa[i], qb[i], qc[i], qs[i]);
            es[i] = m[15:0]; ec[i] = m[16]; eo[i] = m[17];
        end
        stream(1000, 2, span);

        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_i = ha[i]; b_i = hb[i]; cin_i = hc[i]; sub_i = hs[i]; valid_i = 1'b1;
            step;
        end
        valid_i = 1'b0;
        step;
        chk("pre_rst_valid", valid_o, 1);
        chk("pre_rst_s", s_o, 16'h0003);
        #2 rst_i = 1'b1;
        #1;
        chk("async_rst_valid", valid_o, 0);
        chk("async_rst_s", s_o, 0);
        chk("async_rst_ovf", ovf_o, 0);
        step;
        rst_i = 1'b0;
        ready_i = 1'b0;
        #1;
        chk("post_rst_ready", ready_o, 1);
        ready_i = 1'b1;
        a_i = 16'h0001; b_i = 16'h0001; cin_i = 1'b0; sub_i = 1'b0; valid_i = 1'b1;
        step;
        valid_i = 1'b0;
        nv = 0; fl = -1; fs = '0;
        for (int i = 1; i <= 8; i++) begin
            step;
            if (valid_o) begin
                nv++;
                if (fl < 0) begin fl = i; fs = s_o; end
            end
        end
        chk("post_rst_lat", fl, 4);
        chk("post_rst_s", fs, 16'h0002);
        chk("post_rst_count", nv, 1);

        aux_op("px_add", 32'h7FFF_FFFF, 32'h0000_0001, 0, 8'h00, 1, 0, 32'h8000_0000, 0, 1);
        aux_op("px_sub", 32'h8000_0080, 32'h0000_0001, 1, 8'h7F, 1, 1, 32'h8000_007F, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
